// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter.
// Contents:
//   arb_state_e      - arbiter FSM state encoding
//   MEM_LAT_DEFAULT  - default memory latency in cycles
//   CNT_W            - latency counter width
//   lat_load_val()   - counter load value for a given latency
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_D_BUSY = 2'd1,
    ST_I_BUSY = 2'd2,
    ST_HALTED = 2'd3
  } arb_state_e;

  localparam int unsigned MEM_LAT_DEFAULT = 4;
  localparam int unsigned CNT_W           = 4;

  // The issue cycle is one of the MEM_LAT cycles, so the counter starts one short.
  function automatic logic [CNT_W-1:0] lat_load_val(input int unsigned lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Latency down-counter for the memory arbiter.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset (count -> 0)
//   i_load     - load i_load_val this cycle (takes priority over decrement)
//   i_load_val - value to load
//   i_dec      - decrement request; holds at zero rather than wrapping
//   o_zero     - count is zero
module mem_arbiter_lat_counter
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency memory between instruction fetch and the data path.
// Data requests beat fetch; each access is issued with a one-cycle mem_en strobe and
// completes MEM_LAT cycles later with a registered done pulse. HALT lets the access in
// flight finish, then freezes all traffic until reset.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   i_req, i_addr              - fetch request / address
//   d_rd, d_wr, d_addr, d_wdata - data read / write (write wins) / address / store data
//   halt                       - HALT decoded
//   mem_rdata                  - memory read data, valid MEM_LAT cycles after issue
//   mem_en, mem_wr, mem_addr, mem_wdata - memory issue strobe and qualifiers
//   rdata, i_done, d_done      - completion data and one-cycle done pulses
//   i_stall, d_stall           - requester stalls
//   d_err                      - misaligned data access (no memory access)
//   halted                     - sticky halt indication
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 16,
  parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          halt,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] rdata,
  output logic          i_done,
  output logic          d_done,
  output logic          i_stall,
  output logic          d_stall,
  output logic          d_err,
  output logic          halted
);

  arb_state_e    r_state, w_state_d;
  logic          r_halt_pend, w_halt_pend_d;
  logic          r_i_done, r_d_done;
  logic [DW-1:0] r_rdata;

  logic w_d_req;
  logic w_gap;
  logic w_load, w_dec, w_cnt_zero;
  logic w_fin_i, w_fin_d;

  assign w_d_req = d_rd | d_wr;
  // The cycle carrying a done pulse is the mandatory idle cycle between accesses.
  assign w_gap   = r_i_done | r_d_done;

  mem_arbiter_lat_counter u_lat_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (lat_load_val(MEM_LAT)),
    .i_dec      (w_dec),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_state_d     = r_state;
    w_halt_pend_d = r_halt_pend;
    mem_en        = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    d_err         = 1'b0;
    w_load        = 1'b0;
    w_dec         = 1'b0;
    w_fin_i       = 1'b0;
    w_fin_d       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (halt || r_halt_pend) begin
          w_state_d = ST_HALTED;
        end else if (!w_gap) begin
          if (w_d_req && d_addr[0]) begin
            d_err = 1'b1;
          end else if (w_d_req) begin
            // Addr/wdata are only needed on the issue cycle, so live inputs are used directly.
            mem_en    = 1'b1;
            mem_wr    = d_wr;
            mem_addr  = d_addr;
            mem_wdata = d_wr ? d_wdata : '0;
            w_load    = 1'b1;
            w_state_d = ST_D_BUSY;
          end else if (i_req) begin
            mem_en    = 1'b1;
            mem_addr  = i_addr;
            w_load    = 1'b1;
            w_state_d = ST_I_BUSY;
          end
        end
      end

      ST_D_BUSY, ST_I_BUSY: begin
        // Remember a HALT seen mid-access; it takes effect once back in IDLE.
        w_halt_pend_d = r_halt_pend | halt;
        w_dec         = 1'b1;
        if (w_cnt_zero) begin
          w_fin_d   = (r_state == ST_D_BUSY);
          w_fin_i   = (r_state == ST_I_BUSY);
          w_state_d = ST_IDLE;
        end
      end

      ST_HALTED: w_state_d = ST_HALTED;

      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_halt_pend <= 1'b0;
      r_i_done    <= 1'b0;
      r_d_done    <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_d;
      r_halt_pend <= w_halt_pend_d;
      r_i_done    <= w_fin_i;
      r_d_done    <= w_fin_d;
      if (w_fin_i || w_fin_d) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  assign rdata   = r_rdata;
  assign i_done  = r_i_done;
  assign d_done  = r_d_done;
  assign halted  = (r_state == ST_HALTED);
  assign i_stall = i_req & ~r_i_done & ~halted;
  assign d_stall = w_d_req & ~r_d_done & ~d_err & ~halted;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a fixed-latency memory model and a
// scoreboard of expected completions (kind, data, cycle).
module tb_mem_arbiter;

  localparam int unsigned MemLat = 4;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        halt;
  logic [15:0] mem_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] rdata;
  logic        i_done;
  logic        d_done;
  logic        i_stall;
  logic        d_stall;
  logic        d_err;
  logic        halted;

  mem_arbiter #(
    .DW      (16),
    .AW      (16),
    .MEM_LAT (MemLat)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .d_rd      (d_rd),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .halt      (halt),
    .mem_rdata (mem_rdata),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .rdata     (rdata),
    .i_done    (i_done),
    .d_done    (d_done),
    .i_stall   (i_stall),
    .d_stall   (d_stall),
    .d_err     (d_err),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: unwritten locations read as addr ^ 16'h5A3C.
  logic [15:0] mem [logic [15:0]];
  logic [15:0] pipe [MemLat];

  always @(posedge clk) begin
    if (mem_en && !mem_wr) begin
      pipe[0] <= mem.exists(mem_addr) ? mem[mem_addr] : (mem_addr ^ 16'h5A3C);
    end else begin
      pipe[0] <= 16'hDEAD;
    end
    for (int i = 1; i < MemLat; i++) pipe[i] <= pipe[i-1];
    if (mem_en && mem_wr) mem[mem_addr] = mem_wdata;
  end

  assign mem_rdata = pipe[MemLat-1];

  typedef struct {
    logic        is_d;
    logic        is_rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (!rst && (i_done === 1'b1 || d_done === 1'b1)) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done cyc=%0d i_done=%b d_done=%b", cyc, i_done, d_done);
      end else begin
        mon_e = sb.pop_front();
        if (d_done !== mon_e.is_d || i_done !== !mon_e.is_d || cyc != mon_e.cyc ||
            (mon_e.is_rd && rdata !== mon_e.data)) begin
          n_fail++;
          $display("FAIL sb_done got cyc=%0d i_done=%b d_done=%b rdata=%h want cyc=%0d is_d=%b rdata=%h",
                   cyc, i_done, d_done, rdata, mon_e.cyc, mon_e.is_d, mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req   = 1'b0;
    i_addr  = '0;
    d_rd    = 1'b0;
    d_wr    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  task automatic push_exp(input logic is_d, input logic is_rd, input logic [15:0] data,
                          input int done_cyc);
    exp_t e;
    e.is_d  = is_d;
    e.is_rd = is_rd;
    e.data  = data;
    e.cyc   = done_cyc;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    halt = 1'b0;
    clear_inputs();
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, rdata, i_done, d_done, i_stall, d_stall, d_err,
         halted} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got en=%b rdata=%h i_done=%b d_done=%b halted=%b want all 0",
               mem_en, rdata, i_done, d_done, halted);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    int t0;
    i_req  = 1'b1;
    i_addr = 16'h0010;
    @(negedge clk);
    t0 = cyc;
    push_exp(1'b0, 1'b1, 16'h0010 ^ 16'h5A3C, t0 + 5);
    n_checks++;
    if (mem_en !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0010) begin
      n_fail++;
      $display("FAIL fetch_issue got en=%b wr=%b addr=%h want 1 0 0010", mem_en, mem_wr, mem_addr);
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if (i_stall !== (c < 5) || mem_en !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_stall c=%0d got stall=%b en=%b want stall=%b en=0",
                 c, i_stall, mem_en, (c < 5));
      end
    end
    tick();
    clear_inputs();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL fetch_pending got %0d want 0", sb.size());
    end
  endtask

  task automatic test_priority();
    int t0;
    i_req  = 1'b1;
    i_addr = 16'h0200;
    d_rd   = 1'b1;
    d_addr = 16'h0100;
    @(negedge clk);
    t0 = cyc;
    push_exp(1'b1, 1'b1, 16'h0100 ^ 16'h5A3C, t0 + 5);
    push_exp(1'b0, 1'b1, 16'h0200 ^ 16'h5A3C, t0 + 11);
    n_checks++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0100 || i_stall !== 1'b1 || d_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_issue got en=%b addr=%h istall=%b dstall=%b want 1 0100 1 1",
               mem_en, mem_addr, i_stall, d_stall);
    end
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 6) d_rd = 1'b0;
      @(negedge clk);
      n_checks++;
      if (i_stall !== (c < 11) || mem_en !== (c == 6) || (c == 6 && mem_addr !== 16'h0200)) begin
        n_fail++;
        $display("FAIL prio_seq c=%0d got istall=%b en=%b addr=%h want istall=%b en=%b",
                 c, i_stall, mem_en, mem_addr, (c < 11), (c == 6));
      end
    end
    tick();
    clear_inputs();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL prio_pending got %0d want 0", sb.size());
    end
  endtask

  task automatic test_misaligned();
    int t0;
    d_wr    = 1'b1;
    d_addr  = 16'h0021;
    d_wdata = 16'h1234;
    @(negedge clk);
    n_checks++;
    if (d_err !== 1'b1 || mem_en !== 1'b0 || d_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned got err=%b en=%b dstall=%b want 1 0 0", d_err, mem_en, d_stall);
    end
    // A fetch on the very next cycle is issued at once only if the arbiter stayed IDLE.
    tick();
    clear_inputs();
    i_req  = 1'b1;
    i_addr = 16'h0022;
    @(negedge clk);
    t0 = cyc;
    push_exp(1'b0, 1'b1, 16'h0022 ^ 16'h5A3C, t0 + 5);
    n_checks++;
    if (d_err !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 16'h0022) begin
      n_fail++;
      $display("FAIL misaligned_idle got err=%b en=%b addr=%h want 0 1 0022",
               d_err, mem_en, mem_addr);
    end
    for (int c = 1; c <= 6; c++) tick();
    clear_inputs();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL misaligned_pending got %0d want 0", sb.size());
    end
  endtask

  task automatic test_write_read();
    int t0;
    d_wr    = 1'b1;
    d_addr  = 16'h0040;
    d_wdata = 16'hBEEF;
    @(negedge clk);
    t0 = cyc;
    push_exp(1'b1, 1'b0, 16'h0000, t0 + 5);
    n_checks++;
    if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0040 || mem_wdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL write_issue got en=%b wr=%b addr=%h wdata=%h want 1 1 0040 beef",
               mem_en, mem_wr, mem_addr, mem_wdata);
    end
    for (int c = 1; c <= 6; c++) tick();
    d_wr    = 1'b0;
    d_wdata = 16'h0000;
    d_rd    = 1'b1;
    @(negedge clk);
    t0 = cyc;
    push_exp(1'b1, 1'b1, 16'hBEEF, t0 + 5);
    n_checks++;
    if (mem_en !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0040 || mem_wdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL read_issue got en=%b wr=%b addr=%h wdata=%h want 1 0 0040 0000",
               mem_en, mem_wr, mem_addr, mem_wdata);
    end
    for (int c = 1; c <= 6; c++) tick();
    clear_inputs();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL write_read_pending got %0d want 0", sb.size());
    end
  endtask

  task automatic test_halt();
    int t0;
    i_req  = 1'b1;
    i_addr = 16'h0300;
    @(negedge clk);
    t0 = cyc;
    push_exp(1'b0, 1'b1, 16'h0300 ^ 16'h5A3C, t0 + 5);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 2) halt = 1'b1;
      if (c == 7) begin
        d_rd   = 1'b1;
        d_addr = 16'h0050;
      end
      @(negedge clk);
      n_checks++;
      if (halted !== (c >= 6)) begin
        n_fail++;
        $display("FAIL halt_flag c=%0d got %b want %b", c, halted, (c >= 6));
      end
      if (c >= 6) begin
        n_checks++;
        if (mem_en !== 1'b0 || i_stall !== 1'b0 || d_stall !== 1'b0) begin
          n_fail++;
          $display("FAIL halt_frozen c=%0d got en=%b istall=%b dstall=%b want 0 0 0",
                   c, mem_en, i_stall, d_stall);
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL halt_pending got %0d want 0", sb.size());
    end
  endtask

  task automatic test_rst_mid_access();
    int t0;
    rst  = 1'b1;
    halt = 1'b0;
    clear_inputs();
    tick();
    rst = 1'b0;
    tick();
    d_rd   = 1'b1;
    d_addr = 16'h0100;
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b1 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_leaves_halt got en=%b halted=%b want 1 0", mem_en, halted);
    end
    tick();
    tick();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, rdata, i_done, d_done, i_stall, d_stall, d_err,
         halted} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs got en=%b rdata=%h i_done=%b d_done=%b halted=%b want all 0",
               mem_en, rdata, i_done, d_done, halted);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if (d_done !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_no_done c=%0d got %b want 0", c, d_done);
      end
    end
    tick();
    i_req  = 1'b1;
    i_addr = 16'h0400;
    @(negedge clk);
    t0 = cyc;
    push_exp(1'b0, 1'b1, 16'h0400 ^ 16'h5A3C, t0 + 5);
    n_checks++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0400) begin
      n_fail++;
      $display("FAIL rst_then_fetch got en=%b addr=%h want 1 0400", mem_en, mem_addr);
    end
    for (int c = 1; c <= 6; c++) tick();
    clear_inputs();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rst_pending got %0d want 0", sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < MemLat; i++) pipe[i] = 16'hDEAD;
    test_reset();
    test_fetch();
    test_priority();
    test_misaligned();
    test_write_read();
    test_halt();
    test_rst_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
